// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-state FETCH/EXEC instruction fetch unit with PC sequencing (optional FETCH_PERF_EN retired counter)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_retired,
`endif
    output logic [31:0] pc,
    output logic [31:0] pcplus4
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    // Low two bits are forced to zero so a misaligned parameter can never
    // produce an unaligned fetch address.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        imem_req_q;
    logic        instr_valid_q;

    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        retire;

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;

    // An instruction retires only when the datapath finishes it while held;
    // ex_done seen during FETCH is meaningless and must not move the PC.
    assign retire = (state == EXEC) && ex_done;

    // Successor PC selection; all arithmetic wraps naturally at 32 bits and
    // every source keeps bits [1:0] at zero.
    always_comb begin
        pcplus4       = pc_q + 32'd4;
        branch_offset = signimm << 2;
        branch_target = pcplus4 + branch_offset;
        jump_target   = {pcplus4[31:28], instr_q[25:0], 2'b00};
        next_pc       = pcplus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end
    end

    // FETCH/EXEC sequencer with registered handshake outputs; reset wins over
    // any same-cycle imem_ready or ex_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0000_0000;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        state         <= EXEC;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        pc_q          <= next_pc;
                        state         <= FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= FETCH;
                    imem_req_q    <= 1'b1;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Count of retired instructions, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= 32'h0000_0000;
        end else if (retire) begin
            perf_retired <= perf_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic [31:0] pc;
    logic [31:0] pcplus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_retired;
`endif

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
`ifdef FETCH_PERF_EN
        .perf_retired(perf_retired),
`endif
        .pc          (pc),
        .pcplus4     (pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach summary (actual=running, expected=finished)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pcsrc = 0; jump = 0; signimm = 0; imem_rdata = 0; imem_ready = 0; ex_done = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        imem_ready = 1; ex_done = 1; imem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        checks++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_pc: pc=%h addr=%h expected 00000000", pc, imem_addr);
        end
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_instr: instr=%h valid=%b expected 00000000/0", instr, instr_valid);
        end
        checks++;
        if (pcplus4 !== 32'h4) begin
            errors++; $display("FAIL reset_pcplus4: got %h expected 00000004", pcplus4);
        end
        clear_inputs();
        reset = 0;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_req: imem_req=%b expected 1", imem_req);
        end
    endtask

    task automatic test_back_to_back();
        imem_ready = 1; ex_done = 1; imem_rdata = 32'h0000_0020;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i % 2 == 0) begin
                if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'(i / 2 * 4)) begin
                    errors++;
                    $display("FAIL b2b_fetch%0d: req=%b valid=%b addr=%h expected 1/0/%h",
                             i, imem_req, instr_valid, imem_addr, 32'(i / 2 * 4));
                end
            end else begin
                if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h0000_0020) begin
                    errors++;
                    $display("FAIL b2b_exec%0d: req=%b valid=%b instr=%h expected 0/1/00000020",
                             i, imem_req, instr_valid, instr);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_wait_states();
        // pc=0x0C in FETCH; fetch j 0x40 -> target 0x100
        imem_ready = 1; imem_rdata = 32'h0800_0040;
        tick();
        clear_inputs();
        jump = 1; ex_done = 1;
        tick();
        clear_inputs();
        ex_done = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_stable%0d: req=%b addr=%h valid=%b expected 1/00000100/0",
                         i, imem_req, imem_addr, instr_valid);
            end
            if (i < 4) tick();
        end
        ex_done = 0;
        imem_ready = 1; imem_rdata = 32'h2008_0005;
        tick();
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h100) begin
            errors++;
            $display("FAIL wait_capture: instr=%h valid=%b req=%b pc=%h expected 20080005/1/0/00000100",
                     instr, instr_valid, imem_req, pc);
        end
        imem_rdata = 32'h1111_1111;
        tick();
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL exec_ignores_ready: instr=%h valid=%b expected 20080005/1", instr, instr_valid);
        end
        clear_inputs();
    endtask

    task automatic test_branch_jump();
        // EXEC at 0x100: branch 0x104 + (-0x31*4) = 0x40
        pcsrc = 1; signimm = 32'hFFFF_FFCF; ex_done = 1;
        tick();
        clear_inputs();
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++; $display("FAIL branch_setup: addr=%h expected 00000040", imem_addr);
        end
        imem_ready = 1; imem_rdata = 32'h1000_0010;
        tick();
        clear_inputs();
        pcsrc = 1; signimm = 32'hFFFF_FFFE; ex_done = 1;
        tick();
        clear_inputs();
        checks++;
        if (imem_addr !== 32'h3C) begin
            errors++; $display("FAIL branch_back: addr=%h expected 0000003c", imem_addr);
        end
        imem_ready = 1; imem_rdata = 32'h1000_0010;
        tick();
        clear_inputs();
        pcsrc = 1; jump = 1; signimm = 32'hFFFF_FFFE; ex_done = 1;
        tick();
        clear_inputs();
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++; $display("FAIL jump_priority: addr=%h expected 00000040", imem_addr);
        end
    endtask

    task automatic test_wrap();
        imem_ready = 1; imem_rdata = 32'h0;
        tick();
        clear_inputs();
        pcsrc = 1; signimm = 32'hFFFF_FFEE; ex_done = 1;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_setup: pc=%h pcplus4=%h expected fffffffc/00000000", pc, pcplus4);
        end
        imem_ready = 1;
        tick();
        clear_inputs();
        ex_done = 1;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_pc: pc=%h req=%b expected 00000000/1", pc, imem_req);
        end
    endtask

    task automatic test_reset_in_exec();
        imem_ready = 1; imem_rdata = 32'h0800_0123;
        tick();
        clear_inputs();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++; $display("FAIL rst_exec_setup: valid=%b expected 1", instr_valid);
        end
        reset = 1; ex_done = 1; jump = 1;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec: pc=%h valid=%b instr=%h req=%b expected 00000000/0/00000000/1",
                     pc, instr_valid, instr, imem_req);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_retired !== 32'h0) begin
            errors++; $display("FAIL rst_perf: perf_retired=%0d expected 0", perf_retired);
        end
`endif
        reset = 0;
    endtask

    task automatic test_throughput();
        imem_ready = 1; ex_done = 1; imem_rdata = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'(k % 2)) begin
                errors++; $display("FAIL thru_valid%0d: valid=%b expected %b", k, instr_valid, 1'(k % 2));
            end
        end
        clear_inputs();
        checks++;
        if (pc !== 32'd40) begin
            errors++; $display("FAIL thru_pc: pc=%h expected 00000028", pc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_retired !== 32'd10) begin
            errors++; $display("FAIL perf_count: perf_retired=%0d expected 10", perf_retired);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_branch_jump();
        test_wrap();
        test_reset_in_exec();
        test_throughput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pcsrc  input  1  branch taken (beq & zero) for the instruction currently held.
REQ-005 jump  input  1  jump for the instruction currently held.
REQ-006 signimm  input  32  sign-extended immediate of the held instruction.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word-aligned read address, equal to pc.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-010 imem_ready  input  1  memory returns data this cycle.
REQ-011 instr  output  32  held instruction; op=instr[31:26], funct=instr[5:0] feed the decoder.
REQ-012 instr_valid  output  1  instr is valid and being executed.
REQ-013 ex_done  input  1  datapath has completed the held instruction this cycle.
REQ-014 pc  output  32  address of the current instruction.
REQ-015 pcplus4  output  32  pc + 4, combinational.

Function
REQ-016 FSM states: FETCH (imem_req=1, instr_valid=0) and EXEC (imem_req=0, instr_valid=1).
REQ-017 FETCH: when imem_ready=1, capture imem_rdata into instr and move to EXEC the next cycle; otherwise stay, holding pc and imem_addr stable.
REQ-018 imem_ready is permitted in the same cycle imem_req first rises; zero wait states give a one-cycle FETCH.
REQ-019 EXEC: instr held constant; when ex_done=1, load next pc and return to FETCH the next cycle; otherwise stay.
REQ-020 Next pc: jump=1 -> {pcplus4[31:28], instr[25:0], 2'b00}; else pcsrc=1 -> pcplus4 + (signimm << 2); else pcplus4.
REQ-021 jump takes priority over pcsrc when both are 1.
REQ-022 All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-023 imem_ready outside FETCH and ex_done outside EXEC are ignored and change no state.
REQ-024 Minimum throughput: one instruction per 2 cycles (1 FETCH + 1 EXEC).
REQ-025 pc[1:0] is always 2'b00; all target sources above preserve alignment.

Reset
REQ-026 While reset=1 at a clock edge: pc=RESET_PC, state=FETCH, instr=32'h0, instr_valid=0, imem_req=1 the cycle after reset deasserts.
REQ-027 Reset mid-FETCH discards the pending read; reset mid-EXEC discards the held instruction and its PC update.
REQ-028 Reset takes priority over imem_ready and ex_done in the same cycle.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: adds output perf_retired (32 bits), reset to 0, incremented by 1 on each accepted ex_done in EXEC, wrapping 32'hFFFF_FFFF -> 0.
REQ-030 Macro FETCH_PERF_EN undefined: no perf_retired port, no counter logic; all other behaviour identical.

Verification
REQ-031 Reset 3 cycles, imem_ready=1 always, ex_done=1 always -> imem_addr 0x0,0x4,0x8 on successive FETCH cycles, instr_valid toggles every cycle.
REQ-032 pc=0x100, imem_ready held 0 for 4 cycles then 1 with rdata 0x2008_0005 -> imem_req=1 and imem_addr=0x100 stable 5 cycles, then instr=0x2008_0005, instr_valid=1.
REQ-033 pc=0x40, pcsrc=1, signimm=32'hFFFF_FFFE, ex_done=1 -> next imem_addr=0x3C; with jump=1 also set, instr[25:0]=26'h10 -> next imem_addr=0x40.
REQ-034 pc=32'hFFFF_FFFC, no branch, ex_done=1 -> next pc=0x0.
REQ-035 reset=1 in EXEC coincident with ex_done=1 -> pc=RESET_PC, instr_valid=0, perf_retired (when enabled) =0.
REQ-036 FETCH_PERF_EN defined, 10 instructions completed -> perf_retired=10; stray ex_done pulses during FETCH do not increment.
